// File: rtl/mem_io_router.sv
// mem_io_router: steers CPU memory requests either to a small window of
// memory-mapped I/O registers or to the SDRAM driver. One transaction is
// tracked at a time, so the CPU sees a single rdy/cplt handshake for both paths.
module mem_io_router #(
  parameter int                     ADDR_WIDTH  = 16,
  parameter int                     DATA_WIDTH  = 16,
  parameter int                     NUM_IO_REGS = 8,
  parameter logic [ADDR_WIDTH-1:0]  IO_BASE     = 16'hFFF8,
  parameter int                     IO_LATENCY  = 1,
  parameter logic [NUM_IO_REGS-1:0] IO_RO_MASK  = 8'h00,
  parameter logic [DATA_WIDTH-1:0]  IO_RST_VAL0 = 16'hBEEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [DATA_WIDTH-1:0]             mem_data_in,
  input  logic                              mem_r_en,
  input  logic                              mem_w_en,
  output logic                              mem_rdy,
  output logic                              mem_cplt,
  output logic [DATA_WIDTH-1:0]             mem_data_out,
  output logic [ADDR_WIDTH-1:0]             dram_addr,
  output logic [DATA_WIDTH-1:0]             dram_data_in,
  output logic                              dram_r_en,
  output logic                              dram_w_en,
  input  logic                              dram_rdy,
  input  logic                              dram_cplt,
  input  logic [DATA_WIDTH-1:0]             dram_data_out,
  output logic [NUM_IO_REGS*DATA_WIDTH-1:0] io_regs,
  output logic [NUM_IO_REGS-1:0]            io_wr_pulse,
  input  logic [NUM_IO_REGS*DATA_WIDTH-1:0] io_in
);

  localparam int IDX_W = (NUM_IO_REGS > 1) ? $clog2(NUM_IO_REGS) : 1;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IO_LATENCY - 1);
  // Window bounds held one bit wider so a window ending at 2^ADDR_WIDTH
  // still includes the top address.
  localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, IO_BASE};
  localparam logic [ADDR_WIDTH:0] TOP_EXT  = BASE_EXT + (ADDR_WIDTH+1)'(NUM_IO_REGS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRAM_BUSY = 2'd1,
    ST_IO_BUSY   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   cap_q, cap_d;
  logic [NUM_IO_REGS-1:0]  wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_IO_REGS];

  logic [ADDR_WIDTH:0]     addr_ext_s;
  logic                    in_io_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    ro_s;
  logic                    rd_s;
  logic                    wr_s;
  logic                    rdy_s;
  logic                    accept_s;
  logic                    io_acc_s;
  logic                    dram_acc_s;
  logic                    reg_we_s;
  logic [DATA_WIDTH-1:0]   io_rd_val_s;
  logic                    cplt_s;
  logic [DATA_WIDTH-1:0]   cplt_data_s;

  // Address decode, read-priority resolution and the accept condition.
  always_comb begin
    addr_ext_s = {1'b0, mem_addr};
    in_io_s    = (addr_ext_s >= BASE_EXT) && (addr_ext_s < TOP_EXT);
    idx_s      = IDX_W'(mem_addr - IO_BASE);
    ro_s       = IO_RO_MASK[idx_s];
    rd_s       = mem_r_en;
    wr_s       = mem_w_en && !mem_r_en;
    rdy_s      = (state_q == ST_IDLE) && dram_rdy;
    accept_s   = rdy_s && (mem_r_en || mem_w_en);
    io_acc_s   = accept_s && in_io_s;
    dram_acc_s = accept_s && !in_io_s;
    reg_we_s   = io_acc_s && wr_s && !ro_s;
    if (ro_s) begin
      io_rd_val_s = io_in[int'(idx_s)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      io_rd_val_s = regs_q[idx_s];
    end
  end

  // Next-state logic for the transaction tracker plus completion generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cplt_s      = 1'b0;
    cplt_data_s = data_q;
    case (state_q)
      ST_IDLE: begin
        if (io_acc_s) begin
          state_d = ST_IO_BUSY;
          cnt_d   = CNT_LOAD;
        end else if (dram_acc_s) begin
          state_d = ST_DRAM_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAM_BUSY: begin
        if (dram_cplt) begin
          cplt_s      = 1'b1;
          cplt_data_s = dram_data_out;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DRAM_BUSY;
        end
      end
      ST_IO_BUSY: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          cplt_s      = 1'b1;
          cplt_data_s = cap_q;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Capture of I/O read data / write data and the write-strobe pattern.
  always_comb begin
    data_d     = cplt_data_s;
    cap_d      = cap_q;
    wr_pulse_d = {NUM_IO_REGS{1'b0}};
    if (io_acc_s) begin
      if (rd_s) begin
        cap_d = io_rd_val_s;
      end else begin
        cap_d = mem_data_in;
      end
    end else begin
      cap_d = cap_q;
    end
    if (reg_we_s) begin
      wr_pulse_d[idx_s] = 1'b1;
    end else begin
      wr_pulse_d = {NUM_IO_REGS{1'b0}};
    end
  end

  // Tracker state, latency counter, captured and last-completed data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      data_q     <= {DATA_WIDTH{1'b0}};
      cap_q      <= {DATA_WIDTH{1'b0}};
      wr_pulse_q <= {NUM_IO_REGS{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      cap_q      <= cap_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // I/O register file; read-only entries are never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_IO_REGS; i++) begin
        regs_q[i] <= (i == 0) ? IO_RST_VAL0 : {DATA_WIDTH{1'b0}};
      end
    end else if (reg_we_s) begin
      regs_q[idx_s] <= mem_data_in;
    end
  end

  // Flatten the register file onto the io_regs bus.
  genvar g;
  generate
    for (g = 0; g < NUM_IO_REGS; g++) begin : g_flat
      assign io_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end
  endgenerate

  // DRAM requests are only forwarded in a non-I/O accept cycle.
  assign dram_r_en    = dram_acc_s && rd_s;
  assign dram_w_en    = dram_acc_s && wr_s;
  assign dram_addr    = mem_addr;
  assign dram_data_in = mem_data_in;
  assign mem_rdy      = rdy_s;
  assign mem_cplt     = cplt_s;
  assign mem_data_out = cplt_data_s;
  assign io_wr_pulse  = wr_pulse_q;

endmodule
